mem_arbiter: RTL and testbench

- Shares one single-ported memory bus between the CPU instruction-fetch port and the CPU data (load/store) port.
- Arbitrates between the two, registers the winning request onto the memory bus and returns read data and a one-cycle ack to the winner.
- Drives a stall signal so the core freezes PC/IR while an access is outstanding.
- Includes a bus watchdog that aborts accesses the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between the instruction
// fetch port and the data (load/store) port of a CPU core.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   if_req/if_addr   fetch request (held until if_ack) and address
//   if_rdata/if_ack  fetched word and one-cycle completion pulse
//   d_rd/d_wr        data read / write request (held until d_ack)
//   d_addr/d_wdata   data address and store data
//   d_rdata/d_ack    load data and one-cycle completion pulse
//   m_req/m_we       memory strobe and write enable (registered)
//   m_addr/m_wdata   memory address and write data (registered)
//   m_rdata/m_ack    memory read data and completion
//   bus_err          one-cycle pulse alongside the ack of an aborted access
//   stall            combinational core freeze while any access is pending
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          bus_err,
  output logic          stall
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  // Counter value at which an unacknowledged access is aborted.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  logic [1:0]    state,      state_nxt;
  logic [CW-1:0] cnt,        cnt_nxt;
  logic          last_grant, last_grant_nxt;
  logic          m_req_nxt,  m_we_nxt;
  logic [AW-1:0] m_addr_nxt;
  logic [DW-1:0] m_wdata_nxt;
  logic [DW-1:0] if_rdata_nxt, d_rdata_nxt;
  logic          if_ack_nxt, d_ack_nxt, bus_err_nxt;
  logic          d_pend, grant_d;

  assign d_pend = d_rd | d_wr;

  // Core freeze: any request not being acknowledged this cycle.
  assign stall = (if_req & ~if_ack) | (d_pend & ~d_ack);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GRANT_IF;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      m_req      <= m_req_nxt;
      m_we       <= m_we_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_ack     <= if_ack_nxt;
      d_ack      <= d_ack_nxt;
      bus_err    <= bus_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    m_req_nxt      = m_req;
    m_we_nxt       = m_we;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    if_ack_nxt     = 1'b0;
    d_ack_nxt      = 1'b0;
    bus_err_nxt    = 1'b0;
    grant_d        = 1'b0;

    case (state)
      IDLE: begin
        // During an ack cycle the FSM is only just back in IDLE; requests
        // seen now are arbitrated at the following edge.
        if (!(if_ack | d_ack) && (if_req || d_pend)) begin
          grant_d        = d_pend && (!if_req || (last_grant == GRANT_IF));
          cnt_nxt        = '0;
          m_req_nxt      = 1'b1;
          last_grant_nxt = grant_d ? GRANT_D : GRANT_IF;
          if (grant_d) begin
            state_nxt   = BUSY_D;
            m_addr_nxt  = d_addr;
            m_we_nxt    = d_wr;  // rd and wr together is a write
            m_wdata_nxt = d_wdata;
          end else begin
            state_nxt   = BUSY_IF;
            m_addr_nxt  = if_addr;
            m_we_nxt    = 1'b0;
          end
        end
      end

      BUSY_IF, BUSY_D: begin
        if (m_ack) begin
          state_nxt = IDLE;
          m_req_nxt = 1'b0;
          m_we_nxt  = 1'b0;
          if (state == BUSY_D) begin
            d_rdata_nxt = m_rdata;
            d_ack_nxt   = 1'b1;
          end else begin
            if_rdata_nxt = m_rdata;
            if_ack_nxt   = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          // Watchdog abort: complete the access with zero data and an error.
          state_nxt   = IDLE;
          m_req_nxt   = 1'b0;
          m_we_nxt    = 1'b0;
          bus_err_nxt = 1'b1;
          if (state == BUSY_D) begin
            d_rdata_nxt = '0;
            d_ack_nxt   = 1'b1;
          end else begin
            if_rdata_nxt = '0;
            if_ack_nxt   = 1'b1;
          end
        end else if (cnt != {CW{1'b1}}) begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        m_req_nxt = 1'b0;
        m_we_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory with programmable
// wait states, requester tasks, and scoreboards for bus accesses and acks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_rd, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_ack, d_ack;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        bus_err, stall;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .bus_err(bus_err), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; } acc_t;
  typedef struct { logic [31:0] rdata; bit chk_rdata; bit err; } ack_t;

  acc_t exp_acc[$];
  ack_t exp_if[$];
  ack_t exp_d[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'hA5A5_0000 + (a >> 4);
  endfunction

  // Memory model: ack after wait_states extra cycles unless stuck.
  int   wait_states = 0;
  bit   stuck = 1'b0;
  int   wcnt = 0;
  assign m_rdata = mem_val(m_addr);

  always @(negedge clk) begin
    if (m_req && !stuck) begin
      m_ack = (wcnt >= wait_states);
      wcnt  = wcnt + 1;
    end else begin
      m_ack = 1'b0;
      wcnt  = 0;
    end
  end

  // Bus and ack monitor.
  bit          prev_req = 1'b0;
  logic [31:0] snap_addr, snap_wdata;
  bit          snap_we;
  int          req_len = 0;
  int          ack_cnt = 0;

  always @(negedge clk) begin
    acc_t a;
    ack_t k;
    if (m_req && !prev_req) begin
      req_len = 1;
      snap_addr = m_addr; snap_we = m_we; snap_wdata = m_wdata;
      if (exp_acc.size() == 0) chk("unexpected_access", m_addr, 32'hFFFF_FFFF);
      else begin
        a = exp_acc.pop_front();
        chk("m_addr", m_addr, a.addr);
        chk("m_we", 32'(m_we), 32'(a.we));
        if (a.we) chk("m_wdata", m_wdata, a.wdata);
      end
    end else if (m_req) begin
      req_len++;
      chk("m_stable", {m_addr ^ snap_addr} | (m_wdata ^ snap_wdata) | 32'(m_we ^ snap_we), 32'd0);
    end
    prev_req = m_req;

    if (if_ack || d_ack) begin
      ack_cnt++;
      chk("ack_excl", 32'(if_ack & d_ack), 32'd0);
    end
    if (if_ack) begin
      if (exp_if.size() == 0) chk("unexpected_if_ack", 32'd1, 32'd0);
      else begin
        k = exp_if.pop_front();
        if (k.chk_rdata) chk("if_rdata", if_rdata, k.rdata);
        chk("if_bus_err", 32'(bus_err), 32'(k.err));
      end
    end
    if (d_ack) begin
      if (exp_d.size() == 0) chk("unexpected_d_ack", 32'd1, 32'd0);
      else begin
        k = exp_d.pop_front();
        if (k.chk_rdata) chk("d_rdata", d_rdata, k.rdata);
        chk("d_bus_err", 32'(bus_err), 32'(k.err));
      end
    end
  end

  // Fetch requester: called at a negedge, returns at the negedge of its ack.
  task automatic do_fetch(input logic [31:0] addr, input bit err, output int n);
    ack_t k;
    k.rdata = err ? 32'd0 : mem_val(addr); k.chk_rdata = 1'b1; k.err = err;
    exp_if.push_back(k);
    if_req = 1'b1; if_addr = addr;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (if_ack) break;
      if (n > 100) begin chk("if_ack_timeout", 32'(n), 32'd0); break; end
    end
    if_req = 1'b0;
  endtask

  // Data requester.
  task automatic do_data(input logic [31:0] addr, input logic [31:0] wdata,
                         input bit rd, input bit wr, input bit err, output int n);
    ack_t k;
    k.rdata = err ? 32'd0 : mem_val(addr); k.chk_rdata = !wr || err; k.err = err;
    exp_d.push_back(k);
    d_rd = rd; d_wr = wr; d_addr = addr; d_wdata = wdata;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (d_ack) break;
      if (n > 100) begin chk("d_ack_timeout", 32'(n), 32'd0); break; end
    end
    d_rd = 1'b0; d_wr = 1'b0;
  endtask

  function automatic acc_t mk(input logic [31:0] a, input bit we, input logic [31:0] wd);
    acc_t r;
    r.addr = a; r.we = we; r.wdata = wd;
    return r;
  endfunction

  initial begin
    int n;
    int acks0;
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_acks", {29'd0, if_ack, d_ack, bus_err}, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait fetch.
    wait_states = 0;
    exp_acc.push_back(mk(32'h10, 1'b0, 32'h0));
    do_fetch(32'h10, 1'b0, n);
    chk("fetch_latency", 32'(n), 32'd2);
    #1 chk("fetch_stall_after", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);

    // Write with three wait states.
    wait_states = 3;
    exp_acc.push_back(mk(32'h200, 1'b1, 32'h1234_5678));
    do_data(32'h200, 32'h1234_5678, 1'b0, 1'b1, 1'b0, n);
    chk("write_latency", 32'(n), 32'd5);
    chk("write_req_len", 32'(req_len), 32'd4);
    repeat (2) @(negedge clk);

    // Read and write together behave as one write.
    wait_states = 0;
    acks0 = ack_cnt;
    exp_acc.push_back(mk(32'h8, 1'b1, 32'hCAFE_0008));
    do_data(32'h8, 32'hCAFE_0008, 1'b1, 1'b1, 1'b0, n);
    repeat (4) @(negedge clk);
    chk("rdwr_single_ack", 32'(ack_cnt - acks0), 32'd1);

    // Watchdog abort, then a normal fetch.
    stuck = 1'b1;
    exp_acc.push_back(mk(32'h500, 1'b0, 32'h0));
    do_data(32'h500, 32'h0, 1'b1, 1'b0, 1'b1, n);
    chk("wdog_latency", 32'(n), 32'd17);
    chk("wdog_m_req", 32'(m_req), 32'd0);
    stuck = 1'b0;
    @(negedge clk);
    exp_acc.push_back(mk(32'h20, 1'b0, 32'h0));
    do_fetch(32'h20, 1'b0, n);
    chk("post_wdog_latency", 32'(n), 32'd2);
    repeat (2) @(negedge clk);

    // Reset in the middle of an access.
    stuck = 1'b1;
    acks0 = ack_cnt;
    exp_acc.push_back(mk(32'h400, 1'b0, 32'h0));
    d_rd = 1'b1; d_addr = 32'h400;
    repeat (3) @(negedge clk);
    chk("mid_m_req", 32'(m_req), 32'd1);
    chk("mid_stall", 32'(stall), 32'd1);
    #2 reset = 1'b0;
    #1 chk("mid_rst_m_req", 32'(m_req), 32'd0);
    d_rd = 1'b0;
    @(negedge clk);
    reset = 1'b1; stuck = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_ack", 32'(ack_cnt - acks0), 32'd0);

    // Round-robin with both requesters held continuously.
    wait_states = 0;
    exp_acc.push_back(mk(32'h300, 1'b0, 32'h0));
    exp_acc.push_back(mk(32'h40, 1'b0, 32'h0));
    exp_acc.push_back(mk(32'h304, 1'b0, 32'h0));
    exp_acc.push_back(mk(32'h44, 1'b0, 32'h0));
    fork
      begin
        int nd;
        do_data(32'h300, 32'h0, 1'b1, 1'b0, 1'b0, nd);
        do_data(32'h304, 32'h0, 1'b1, 1'b0, 1'b0, nd);
      end
      begin
        int nf;
        do_fetch(32'h40, 1'b0, nf);
        do_fetch(32'h44, 1'b0, nf);
      end
    join
    repeat (4) @(negedge clk);

    chk("exp_acc_empty", 32'(exp_acc.size()), 32'd0);
    chk("exp_if_empty", 32'(exp_if.size()), 32'd0);
    chk("exp_d_empty", 32'(exp_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
